// File: rtl/tq_qp_divmod_pipe_pkg.sv
// Shared constants and helpers for the QP decomposer: defaults, H.264 chroma QP table,
// clip3 and an exact multiply-shift divide-by-6 for 8-bit operands.
package tq_qp_divmod_pipe_pkg;

    localparam int QP_MAX_DEF     = 51;
    localparam int QBITS_BASE_DEF = 15;
    localparam int CQP_TAB_LEN    = 22;

    // QPc for qPI = 30..51
    localparam logic [5:0] CQP_TAB [CQP_TAB_LEN] = '{
        6'd29, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd36,
        6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd38, 6'd39, 6'd39, 6'd39, 6'd39
    };

    function automatic int clip3(input int lo, input int hi, input int v);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int chroma_map(input int qpi);
        return (qpi < 30) ? qpi : int'(CQP_TAB[5'(qpi - 30)]);
    endfunction

    // 171/1024 overshoots 1/6 by little enough to stay exact for x <= 509
    function automatic logic [7:0] div6(input logic [7:0] x);
        logic [17:0] p;
        p = 18'(x) * 18'd171;
        return 8'(p >> 10);
    endfunction

endpackage

// File: rtl/tq_qp_divmod_pipe_if.sv
// Valid/ready bundle of the QP decomposer; cqp_ofs_i exists only with TQ_CHROMA_QP_EN.
interface tq_qp_divmod_pipe_if
    import tq_qp_divmod_pipe_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int QP_W       = 6,
    parameter int QP_MAX     = QP_MAX_DEF,
    parameter int QBITS_BASE = QBITS_BASE_DEF
);
    localparam int DIV_W = $clog2(QP_MAX / 6 + 1);
    localparam int QB_W  = $clog2(QBITS_BASE + QP_MAX / 6 + 1);

    logic                         flush_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [N_CH-1:0][QP_W-1:0]    qp_i;
`ifdef TQ_CHROMA_QP_EN
    logic signed [4:0]            cqp_ofs_i;
`endif
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [N_CH-1:0][DIV_W-1:0]   div_o;
    logic [N_CH-1:0][2:0]         mod_o;
    logic [N_CH-1:0][QB_W-1:0]    qbits_o;
    logic [N_CH-1:0]              clamp_o;

    modport master (
        output flush_i, in_valid_i, qp_i, out_ready_i,
        input  in_ready_o, out_valid_o, div_o, mod_o, qbits_o, clamp_o
`ifdef TQ_CHROMA_QP_EN
        , output cqp_ofs_i
`endif
    );

    modport slave (
        input  flush_i, in_valid_i, qp_i, out_ready_i,
        output in_ready_o, out_valid_o, div_o, mod_o, qbits_o, clamp_o
`ifdef TQ_CHROMA_QP_EN
        , input cqp_ofs_i
`endif
    );

endinterface

// File: rtl/tq_qp_divmod_pipe_lane.sv
// One channel's combinational decompose: qc -> qc/6, qc%6, QBITS_BASE + qc/6.
module tq_qp_divmod_pipe_lane
    import tq_qp_divmod_pipe_pkg::*;
#(
    parameter int QP_W       = 6,
    parameter int DIV_W      = 4,
    parameter int QB_W       = 5,
    parameter int QBITS_BASE = QBITS_BASE_DEF
)(
    input  logic [QP_W-1:0]  qc,
    output logic [DIV_W-1:0] div,
    output logic [2:0]       mod,
    output logic [QB_W-1:0]  qbits
);
    logic [7:0] q8, d8, m8;

    always_comb begin
        q8 = 8'(qc);
        d8 = div6(q8);
        m8 = q8 - d8 * 8'd6;
    end

    assign div   = DIV_W'(d8);
    assign mod   = 3'(m8);
    assign qbits = QB_W'(QBITS_BASE) + QB_W'(d8);

endmodule

// File: rtl/tq_qp_divmod_pipe.sv
// Two-stage pipelined QP clamp/decompose (QP/6, QP%6, qbits) for N_CH channels.
// Optional chroma QP mapping in the capture stage with TQ_CHROMA_QP_EN.
module tq_qp_divmod_pipe
    import tq_qp_divmod_pipe_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int QP_W       = 6,
    parameter int QP_MAX     = QP_MAX_DEF,
    parameter int QBITS_BASE = QBITS_BASE_DEF
`ifdef TQ_CHROMA_QP_EN
    , parameter logic [N_CH-1:0] CHROMA_MASK = N_CH'(3'b110)
`endif
)(
    input  logic              clk,
    input  logic              rst,
    tq_qp_divmod_pipe_if.slave io
);
    localparam int DIV_W = $clog2(QP_MAX / 6 + 1);
    localparam int QB_W  = $clog2(QBITS_BASE + QP_MAX / 6 + 1);
    localparam logic [QP_W-1:0] QP_MAX_V = QP_W'(QP_MAX);

    logic s1_v, s2_v, s2_adv, s1_load, accept;
    logic [N_CH-1:0][QP_W-1:0]  qc_n, s1_qc;
    logic [N_CH-1:0]            clamp_n, s1_clamp, s2_clamp;
    logic [N_CH-1:0][DIV_W-1:0] lane_div, s2_div;
    logic [N_CH-1:0][2:0]       lane_mod, s2_mod;
    logic [N_CH-1:0][QB_W-1:0]  lane_qbits, s2_qbits;

    assign s2_adv  = !s2_v || io.out_ready_i;
    assign s1_load = !s1_v || s2_adv;
    assign accept  = io.in_valid_i && s1_load && !io.flush_i;

    // clamp flag always reflects the raw QP, even when chroma mapping overrides qc
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            clamp_n[c] = (io.qp_i[c] > QP_MAX_V);
            qc_n[c]    = clamp_n[c] ? QP_MAX_V : io.qp_i[c];
`ifdef TQ_CHROMA_QP_EN
            if (CHROMA_MASK[c])
                qc_n[c] = QP_W'(chroma_map(clip3(0, QP_MAX,
                                int'(io.qp_i[c]) + int'(io.cqp_ofs_i))));
`endif
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        tq_qp_divmod_pipe_lane #(
            .QP_W(QP_W), .DIV_W(DIV_W), .QB_W(QB_W), .QBITS_BASE(QBITS_BASE)
        ) u_lane (
            .qc(s1_qc[c]), .div(lane_div[c]), .mod(lane_mod[c]), .qbits(lane_qbits[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_qc    <= '0;
            s1_clamp <= '0;
            s2_v     <= 1'b0;
            s2_div   <= '0;
            s2_mod   <= '0;
            s2_qbits <= '0;
            s2_clamp <= '0;
        end else begin
            if (io.flush_i)   s1_v <= 1'b0;
            else if (s1_load) s1_v <= io.in_valid_i;
            if (accept) begin
                s1_qc    <= qc_n;
                s1_clamp <= clamp_n;
            end
            if (io.flush_i)  s2_v <= 1'b0;
            else if (s2_adv) s2_v <= s1_v;
            if (s2_adv && s1_v) begin
                s2_div   <= lane_div;
                s2_mod   <= lane_mod;
                s2_qbits <= lane_qbits;
                s2_clamp <= s1_clamp;
            end
        end
    end

    assign io.in_ready_o  = s1_load;
    assign io.out_valid_o = s2_v;
    assign io.div_o       = s2_div;
    assign io.mod_o       = s2_mod;
    assign io.qbits_o     = s2_qbits;
    assign io.clamp_o     = s2_clamp;

endmodule
